// File: rtl/mod_reduce_seq_ctrl_if.sv
// Handshake and LUT-bank bundle for the mod-4051 residue sequencer.
// master: the sequencer itself; slave: operand source, LUT bank and consumer.
interface mod_reduce_seq_ctrl_if #(
   parameter int IN_W    = 300,
   parameter int CHUNK_W = 6,
   parameter int RES_W   = 12,
   parameter int IDX_W   = 6
);
   // operand input side
   logic               in_valid;
   logic               in_ready;
   logic [IN_W-1:0]    in_data;
   // external LUT bank
   logic               lut_en;
   logic [IDX_W-1:0]   lut_sel;
   logic [CHUNK_W-1:0] lut_x;
   logic [RES_W-1:0]   lut_z;
   // residue output side
   logic               out_valid;
   logic               out_ready;
   logic [RES_W-1:0]   out_res;
   logic               lut_err;

   modport master (
      input  in_valid, in_data, lut_z, out_ready,
      output in_ready, lut_en, lut_sel, lut_x, out_valid, out_res, lut_err
   );

   modport slave (
      output in_valid, in_data, lut_z, out_ready,
      input  in_ready, lut_en, lut_sel, lut_x, out_valid, out_res, lut_err
   );
endinterface

// File: rtl/mod_reduce_seq_ctrl.sv
// Chunk-serial modular reducer: walks a wide operand 6 bits per cycle,
// LSB chunk first, looks up each chunk's weighted residue in an external
// LUT bank and accumulates it modulo MOD with a single conditional subtract.
module mod_reduce_seq_ctrl #(
   parameter int MOD        = 4051,
   parameter int IN_W       = 300,
   parameter int CHUNK_W    = 6,
   parameter int RES_W      = 12,
   parameter int NCHUNK     = 50,
   parameter int IDX_W      = 6,
   parameter int EARLY_EXIT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   mod_reduce_seq_ctrl_if.master bus
);

   localparam int              SH_W  = NCHUNK * CHUNK_W;
   localparam int              RW1   = RES_W + 1;
   localparam logic [RES_W:0]  MOD_S = RW1'(MOD);
   localparam bit              EE    = (EARLY_EXIT != 0);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q;
   logic [RES_W-1:0]     acc_q;
   logic [RES_W-1:0]     acc_d;
   logic [IDX_W-1:0]     idx_q;
   logic [SH_W-1:0]      shreg_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic [RES_W-1:0]     out_res_q;
   logic                 lut_err_q;

   logic                 run;
   logic                 all_zero;
   logic                 last_chunk;
   logic                 lut_bad;

   // Modular add of two residues; inputs below MOD need at most one subtract.
   function automatic logic [RES_W-1:0] mod_add(input logic [RES_W-1:0] a,
                                                input logic [RES_W-1:0] b);
      logic [RES_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= MOD_S) begin
         s = s - MOD_S;
      end
      return s[RES_W-1:0];
   endfunction

   assign run        = (state_q == RUN);
   assign all_zero   = (shreg_q == '0);
   assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
   assign lut_bad    = ({1'b0, bus.lut_z} >= MOD_S);
   assign acc_d      = mod_add(acc_q, bus.lut_z);

   // LUT drive is decoded from state so the bank sees the chunk in the same cycle.
   assign bus.lut_en  = run;
   assign bus.lut_sel = run ? idx_q : '0;
   assign bus.lut_x   = run ? shreg_q[CHUNK_W-1:0] : '0;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_res   = out_res_q;
   assign bus.lut_err   = lut_err_q;

   // Control FSM with registered handshake outputs and the accumulation datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
         lut_err_q   <= 1'b0;
      end else begin
         lut_err_q <= run && lut_bad;
         case (state_q)
            IDLE: begin
               if (!in_ready_q) begin
                  in_ready_q <= 1'b1;
               end else if (bus.in_valid) begin
                  shreg_q    <= SH_W'(bus.in_data);
                  acc_q      <= '0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               if (EE && all_zero) begin
                  // Remaining chunks contribute nothing; lut_z is ignored.
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  out_res_q   <= acc_q;
               end else begin
                  acc_q   <= acc_d;
                  shreg_q <= shreg_q >> CHUNK_W;
                  idx_q   <= idx_q + IDX_W'(1);
                  if (last_chunk) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     out_res_q   <= acc_d;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  out_res_q   <= '0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_reduce_seq_ctrl.sv
// Bench for mod_reduce_seq_ctrl: an early-exit instance and a full-walk
// instance, a behavioural LUT bank, directed vectors, corner sequences and a
// randomized regression against a bit-serial reference residue.
module tb_mod_reduce_seq_ctrl;

   localparam int MOD     = 4051;
   localparam int IN_W    = 300;
   localparam int CHUNK_W = 6;
   localparam int RES_W   = 12;
   localparam int NCHUNK  = 50;
   localparam int IDX_W   = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            tb_valid = 1'b0;
   logic            tb_ready = 1'b0;
   logic [IN_W-1:0] tb_data  = '0;
   logic            which    = 1'b0;
   logic            bad      = 1'b0;

   int errs   = 0;
   int checks = 0;

   mod_reduce_seq_ctrl_if #(.IN_W(IN_W), .CHUNK_W(CHUNK_W), .RES_W(RES_W), .IDX_W(IDX_W)) a_if ();
   mod_reduce_seq_ctrl_if #(.IN_W(IN_W), .CHUNK_W(CHUNK_W), .RES_W(RES_W), .IDX_W(IDX_W)) b_if ();

   mod_reduce_seq_ctrl #(.MOD(MOD), .IN_W(IN_W), .CHUNK_W(CHUNK_W), .RES_W(RES_W),
                         .NCHUNK(NCHUNK), .IDX_W(IDX_W), .EARLY_EXIT(1))
      u_ee (.clk(clk), .rst(rst), .bus(a_if));

   mod_reduce_seq_ctrl #(.MOD(MOD), .IN_W(IN_W), .CHUNK_W(CHUNK_W), .RES_W(RES_W),
                         .NCHUNK(NCHUNK), .IDX_W(IDX_W), .EARLY_EXIT(0))
      u_full (.clk(clk), .rst(rst), .bus(b_if));

   // LUT bank model: weighted residue of one chunk.
   function automatic logic [11:0] lut_fn(input logic [5:0] x, input logic [5:0] s);
      int p;
      p = 1;
      for (int i = 0; i < int'(s); i++) p = (p * 64) % MOD;
      return 12'((int'(x) * p) % MOD);
   endfunction

   // Reference residue: bit-serial Horner evaluation of the whole operand.
   function automatic logic [11:0] ref_mod(input logic [IN_W-1:0] d);
      int r;
      r = 0;
      for (int i = IN_W - 1; i >= 0; i--) r = (r * 2 + int'(d[i])) % MOD;
      return 12'(r);
   endfunction

   // Reference latency from the highest nonzero chunk.
   function automatic int ref_lat(input logic [IN_W-1:0] d, input bit ee);
      int top;
      int k;
      if (!ee) return NCHUNK;
      top = -1;
      for (int i = 0; i < IN_W; i++) if (d[i]) top = i;
      k = (top < 0) ? 0 : top / CHUNK_W + 1;
      return (k + 1 > NCHUNK) ? NCHUNK : k + 1;
   endfunction

   function automatic logic [IN_W-1:0] rand_wide(input int len);
      logic [319:0]    t;
      logic [IN_W-1:0] m;
      for (int k = 0; k < 10; k++) t[k*32 +: 32] = $urandom;
      m = '1;
      if (len == 0) m = '0;
      else m = m >> (IN_W - len);
      return t[IN_W-1:0] & m;
   endfunction

   assign a_if.in_valid  = tb_valid & ~which;
   assign a_if.in_data   = tb_data;
   assign a_if.out_ready = tb_ready & ~which;
   assign a_if.lut_z     = (bad & ~which) ? 12'hFFF : lut_fn(a_if.lut_x, a_if.lut_sel);
   assign b_if.in_valid  = tb_valid & which;
   assign b_if.in_data   = tb_data;
   assign b_if.out_ready = tb_ready & which;
   assign b_if.lut_z     = (bad & which) ? 12'hFFF : lut_fn(b_if.lut_x, b_if.lut_sel);

   logic             o_in_ready, o_lut_en, o_out_valid, o_lut_err;
   logic [IDX_W-1:0] o_lut_sel;
   logic [5:0]       o_lut_x;
   logic [11:0]      o_out_res;
   assign o_in_ready  = which ? b_if.in_ready  : a_if.in_ready;
   assign o_lut_en    = which ? b_if.lut_en    : a_if.lut_en;
   assign o_lut_sel   = which ? b_if.lut_sel   : a_if.lut_sel;
   assign o_lut_x     = which ? b_if.lut_x     : a_if.lut_x;
   assign o_out_valid = which ? b_if.out_valid : a_if.out_valid;
   assign o_out_res   = which ? b_if.out_res   : a_if.out_res;
   assign o_lut_err   = which ? b_if.lut_err   : a_if.lut_err;

   int sel_log[64];
   int x_log[64];
   int run_cnt;
   int err_cnt;
   int err_pos;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic note_err();
      if (o_lut_err) begin
         if (err_cnt == 0) err_pos = run_cnt;
         err_cnt++;
      end
   endtask

   task automatic check_outputs_zero(input string nm);
      chk({nm, "_in_ready"}, 64'(o_in_ready), 0);
      chk({nm, "_lut_en"}, 64'(o_lut_en), 0);
      chk({nm, "_lut_sel"}, 64'(o_lut_sel), 0);
      chk({nm, "_lut_x"}, 64'(o_lut_x), 0);
      chk({nm, "_out_valid"}, 64'(o_out_valid), 0);
      chk({nm, "_out_res"}, 64'(o_out_res), 0);
      chk({nm, "_lut_err"}, 64'(o_lut_err), 0);
   endtask

   // One full transaction: accept, walk, optional stall in DONE, handshake.
   task automatic run_op(input logic [IN_W-1:0] d, input int stall, input bit hold_valid,
                         input int bad_at, output int latency, output logic [11:0] result);
      int w;
      int cnt;
      w = 0;
      while (!o_in_ready && w < 100) begin tick(); w++; end
      chk("in_ready_before_accept", 64'(o_in_ready), 1);
      tb_data  = d;
      tb_valid = 1'b1;
      tick();
      tb_valid = 1'b0;
      tb_data  = rand_wide(IN_W);
      cnt = 0; run_cnt = 0; err_cnt = 0; err_pos = -1;
      while (!o_out_valid && cnt < 120) begin
         note_err();
         if (o_lut_en) begin
            if (run_cnt < 64) begin
               sel_log[run_cnt] = int'(o_lut_sel);
               x_log[run_cnt]   = int'(o_lut_x);
            end
            run_cnt++;
         end
         bad = (bad_at >= 0) && o_lut_en && (int'(o_lut_sel) == bad_at);
         tick();
         bad = 1'b0;
         cnt++;
      end
      chk("out_valid_arrives", 64'(o_out_valid), 1);
      note_err();
      latency = cnt;
      result  = o_out_res;
      for (int i = 0; i < stall; i++) begin
         tb_valid = hold_valid;
         tb_data  = rand_wide(IN_W);
         tick();
         note_err();
         chk("stall_out_valid", 64'(o_out_valid), 1);
         chk("stall_out_res", 64'(o_out_res), 64'(result));
         chk("stall_in_ready", 64'(o_in_ready), 0);
      end
      tb_valid = 1'b0;
      tb_ready = 1'b1;
      tick();
      tb_ready = 1'b0;
      chk("hs_out_valid", 64'(o_out_valid), 0);
      chk("hs_out_res", 64'(o_out_res), 0);
      chk("hs_in_ready", 64'(o_in_ready), 1);
   endtask

   task automatic check_op(input string nm, input logic [IN_W-1:0] d, input bit sel,
                           input logic [11:0] exp_res, input int exp_lat, input int stall,
                           input bit hold_valid);
      int lat;
      logic [11:0] res;
      which = sel;
      run_op(d, stall, hold_valid, -1, lat, res);
      chk({nm, "_res"}, 64'(res), 64'(exp_res));
      chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({nm, "_no_lut_err"}, 64'(err_cnt), 0);
   endtask

   typedef struct {
      logic [IN_W-1:0] d;
      bit              sel;
      logic [11:0]     res;
      int              lat;
   } vec_t;

   vec_t vt[8];

   initial begin
      logic [IN_W-1:0] ones;
      logic [IN_W-1:0] d;
      logic [11:0]     res;
      int              lat;
      int              w;
      bit              seq_ok;
      ones = '1;

      vt[0] = '{d: IN_W'(1),     sel: 1'b0, res: 12'd1,        lat: 2};
      vt[1] = '{d: IN_W'(0),     sel: 1'b0, res: 12'd0,        lat: 1};
      vt[2] = '{d: IN_W'(4051),  sel: 1'b0, res: 12'd0,        lat: 3};
      vt[3] = '{d: IN_W'(4050),  sel: 1'b0, res: 12'd4050,     lat: 3};
      vt[4] = '{d: IN_W'(64),    sel: 1'b0, res: 12'd64,       lat: 3};
      vt[5] = '{d: IN_W'(12345), sel: 1'b0, res: 12'd192,      lat: 4};
      vt[6] = '{d: ones,         sel: 1'b0, res: ref_mod(ones), lat: 50};
      vt[7] = '{d: IN_W'(1),     sel: 1'b1, res: 12'd1,        lat: 50};

      // Reset values, then in_ready one edge after release.
      #12;
      check_outputs_zero("reset");
      @(posedge clk);
      #3 rst = 1'b0;
      chk("in_ready_low_after_release", 64'(o_in_ready), 0);
      tick();
      chk("in_ready_first_edge", 64'(o_in_ready), 1);

      // Directed vectors.
      for (int i = 0; i < 8; i++) begin
         check_op($sformatf("vec%0d", i), vt[i].d, vt[i].sel, vt[i].res, vt[i].lat, 0, 1'b0);
         if (i == 4) begin
            chk("vec64_sel_run1", 64'(sel_log[1]), 1);
            chk("vec64_x_run1", 64'(x_log[1]), 1);
         end
         if (i == 6) begin
            chk("ones_run_cycles", 64'(run_cnt), 50);
            seq_ok = 1'b1;
            for (int j = 0; j < 50; j++) if (sel_log[j] != j) seq_ok = 1'b0;
            chk("ones_sel_sequence", 64'(seq_ok), 1);
         end
      end

      // Back-pressure: 10 stalled cycles with in_valid asserted, then a fresh operand.
      check_op("backpressure", IN_W'(5000), 1'b0, 12'd949, 4, 10, 1'b1);
      check_op("after_bp", IN_W'(777), 1'b0, 12'd777, 3, 0, 1'b0);

      // Asynchronous reset in the middle of a walk.
      which = 1'b0;
      tb_data = ones;
      tb_valid = 1'b1;
      tick();
      tb_valid = 1'b0;
      w = 0;
      while (o_lut_sel != IDX_W'(20) && w < 100) begin tick(); w++; end
      chk("midrun_idx20", 64'(o_lut_sel), 20);
      #2 rst = 1'b1;
      #1;
      check_outputs_zero("midrun_reset");
      @(posedge clk);
      #2 rst = 1'b0;
      tick();
      chk("in_ready_after_midrun_reset", 64'(o_in_ready), 1);
      check_op("post_reset_12345", IN_W'(12345), 1'b0, 12'd192, 4, 0, 1'b0);

      // Out-of-range LUT result at chunk 3 pulses lut_err exactly once.
      which = 1'b0;
      run_op(ones, 0, 1'b0, 3, lat, res);
      chk("lut_err_pulses", 64'(err_cnt), 1);
      chk("lut_err_position", 64'(err_pos), 4);

      // Randomized regression with stalls on both instances.
      for (int n = 0; n < 1350; n++) begin
         bit s;
         s = (n >= 1200);
         d = rand_wide(int'($urandom_range(0, IN_W)));
         check_op("rand", d, s, ref_mod(d), ref_lat(d, !s),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errs, checks);
      $fatal(1, "watchdog");
   end

endmodule
